// File: rtl/truth_sweep_capture.sv
// truth_sweep_capture: walks a 4-bit vector through 0..15, holding each one
// for DWELL clocks. It samples a single-bit unit-under-test output once per
// vector, builds the 16-entry truth table and compares it with an expected
// table. It reports pass, the mismatch count and the lowest failing vector.
module truth_sweep_capture #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        y_in,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail
);

  typedef enum logic {IDLE, SWEEP} state_t;

  // Counter reload value. DWELL is 1..255, so it fits in eight bits.
  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  state_t      state;
  logic [7:0]  dwell_cnt;
  logic [15:0] exp_q;
  logic        sample_miss;
  logic [4:0]  next_cnt;

  // Mismatch flag for the vector currently on sel, and the count including it.
  // With five bits the count reaches 16 without wrapping.
  always_comb begin
    sample_miss = (y_in != exp_q[sel]);
    next_cnt    = mismatch_cnt + {4'b0000, sample_miss};
  end

  // Sweep controller. All outputs are registered here. The last sample also
  // returns the block to idle and resolves pass in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dwell_cnt    <= '0;
      exp_q        <= '0;
      sel          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q        <= expected;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            sel          <= '0;
            dwell_cnt    <= RELOAD;
            busy         <= 1'b1;
            state        <= SWEEP;
          end
        end
        SWEEP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            sel   <= '0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (dwell_cnt != 8'd0) begin
            dwell_cnt <= dwell_cnt - 8'd1;
          end else begin
            table_out[sel] <= y_in;
            mismatch_cnt   <= next_cnt;
            if (sample_miss && (mismatch_cnt == 5'd0)) begin
              first_fail <= sel;
            end
            if (sel != 4'hF) begin
              sel       <= sel + 4'd1;
              dwell_cnt <= RELOAD;
            end else begin
              sel   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (next_cnt == 5'd0);
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_sweep_capture.sv
// tb_truth_sweep_capture: directed checks of the truth-table sweeper. Two
// instances are used: DWELL=4 for full sweeps, abort and reset, and DWELL=1
// for the consecutive-cycle sequence and the ignored restart.
module tb_truth_sweep_capture;

  logic        clk;
  logic        rst_n;

  logic        start4, abort4, y4;
  logic [15:0] exp4;
  logic [15:0] uut4;
  logic [3:0]  sel4;
  logic        busy4, done4, pass4;
  logic [15:0] tab4;
  logic [4:0]  cnt4;
  logic [3:0]  ff4;

  logic        start1, abort1, y1;
  logic [15:0] exp1;
  logic [3:0]  sel1;
  logic        busy1, done1, pass1;
  logic [15:0] tab1;
  logic [4:0]  cnt1;
  logic [3:0]  ff1;

  int n_cmp;
  int n_fail;

  truth_sweep_capture #(.DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .expected(exp4), .y_in(y4), .sel(sel4), .busy(busy4), .done(done4),
    .pass(pass4), .table_out(tab4), .mismatch_cnt(cnt4), .first_fail(ff4)
  );

  truth_sweep_capture #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(exp1), .y_in(y1), .sel(sel1), .busy(busy1), .done(done1),
    .pass(pass1), .table_out(tab1), .mismatch_cnt(cnt1), .first_fail(ff1)
  );

  // Behavioural unit under test: a lookup of its truth table.
  assign y4 = uut4[sel4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] uut;
    logic [15:0] expv;
    logic [15:0] tab;
    logic        pass;
    logic [4:0]  cnt;
    logic [3:0]  first;
  } vec_t;

  vec_t vecs[4];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] want);
    n_cmp++;
    if (actual !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, want);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start on the 4-cycle instance. It is accepted at the next edge.
  task automatic apply_stimulus(input logic [15:0] uut, input logic [15:0] expv);
    uut4   = uut;
    exp4   = expv;
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    start4 = 0; abort4 = 0; exp4 = '0; uut4 = '0;
    start1 = 0; abort1 = 0; exp1 = '0; y1 = 1'b1;
    rst_n  = 1'b0;

    // Reference f(A,B,C,D), a mux fault with I4 stuck at 1 (vectors 8 and 9),
    // an inverted unit, and a lone miss on the last vector.
    vecs[0] = '{16'h48A5, 16'h48A5, 16'h48A5, 1'b1, 5'd0,  4'd0};
    vecs[1] = '{16'h4BA5, 16'h48A5, 16'h4BA5, 1'b0, 5'd2,  4'd8};
    vecs[2] = '{16'hB75A, 16'h48A5, 16'hB75A, 1'b0, 5'd16, 4'd0};
    vecs[3] = '{16'h8000, 16'h0000, 16'h8000, 1'b0, 5'd1,  4'd15};

    #2;
    check_output("reset_outputs", {sel4, busy4, done4, pass4, tab4, cnt4, ff4}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Full sweeps from the vector table.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i].uut, vecs[i].expv);
      check_output($sformatf("v%0d_sel_at_k", i), {28'd0, sel4}, 32'd0);
      check_output($sformatf("v%0d_busy_at_k", i), {31'd0, busy4}, 32'd1);
      tick(63);
      check_output($sformatf("v%0d_done_k63", i), {30'd0, busy4, done4}, 32'b10);
      tick(1);
      check_output($sformatf("v%0d_done_k64", i), {30'd0, busy4, done4}, 32'b01);
      check_output($sformatf("v%0d_table", i), {16'd0, tab4}, {16'd0, vecs[i].tab});
      check_output($sformatf("v%0d_pass", i), {31'd0, pass4}, {31'd0, vecs[i].pass});
      check_output($sformatf("v%0d_cnt", i), {27'd0, cnt4}, {27'd0, vecs[i].cnt});
      if (vecs[i].cnt != 5'd0)
        check_output($sformatf("v%0d_first", i), {28'd0, ff4}, {28'd0, vecs[i].first});
      check_output($sformatf("v%0d_sel_idle", i), {28'd0, sel4}, 32'd0);
    end

    // DWELL=1: sel advances every cycle, and a second start is ignored.
    exp1   = 16'hFFFF;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    check_output("d1_sel_0", {28'd0, sel1}, 32'd0);
    for (int n = 1; n < 16; n++) begin
      start1 = (n == 8);
      tick(1);
      check_output($sformatf("d1_sel_%0d", n), {28'd0, sel1}, n);
      check_output($sformatf("d1_done_%0d", n), {31'd0, done1}, 32'd0);
    end
    start1 = 1'b0;
    tick(1);
    check_output("d1_done_k16", {29'd0, busy1, done1, pass1}, 32'b011);
    check_output("d1_table", {16'd0, tab1}, 32'h0000FFFF);
    check_output("d1_sel_idle", {28'd0, sel1}, 32'd0);

    // Abort while vector 7 is active. The inverted unit leaves partial counts.
    apply_stimulus(16'hB75A, 16'h48A5);
    tick(29);
    abort4 = 1'b1;
    tick(1);
    abort4 = 1'b0;
    check_output("abort_ctrl", {26'd0, sel4, busy4, done4}, 32'd0);
    check_output("abort_pass", {31'd0, pass4}, 32'd0);
    check_output("abort_table", {16'd0, tab4}, 32'h0000005A);
    check_output("abort_cnt", {27'd0, cnt4}, 32'd7);
    check_output("abort_first", {28'd0, ff4}, 32'd0);
    abort4 = 1'b1;
    tick(1);
    abort4 = 1'b0;
    check_output("abort_idle_ignored", {31'd0, busy4}, 32'd0);

    // start and abort together while idle: start wins.
    uut4   = 16'h48A5;
    exp4   = 16'h48A5;
    start4 = 1'b1;
    abort4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    abort4 = 1'b0;
    check_output("start_abort_idle", {31'd0, busy4}, 32'd1);

    // Asynchronous reset mid-sweep, then a normal full sweep.
    tick(20);
    #1 rst_n = 1'b0;
    #1;
    check_output("async_reset", {sel4, busy4, done4, pass4, tab4, cnt4, ff4}, 32'd0);
    #1 rst_n = 1'b1;
    tick(1);
    apply_stimulus(16'h48A5, 16'h48A5);
    tick(64);
    check_output("post_reset_done", {29'd0, busy4, done4, pass4}, 32'b011);
    check_output("post_reset_table", {16'd0, tab4}, 32'h000048A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
